// File: rtl/ssd_pkg.sv
// ============================================================================
// Module : ssd_pkg
// Brief  : Shared types and constants for the seven-segment scan controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ssd_pkg;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } scan_state_t;

    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;
    localparam logic [3:0] C_AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; entry N sits at bits [7N+6:7N].
    localparam logic [15:0][6:0] C_HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

`default_nettype wire

// File: rtl/ssd_step_debounce.sv
// ============================================================================
// Module : ssd_step_debounce
// Brief  : Synchronises and debounces the step button; emits one pulse per press.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ssd_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= 2'b00;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], btn_in};
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
            // Level flips only after a full run of disagreeing samples.
            if (r_sync[1] != r_level) begin
                if (r_cnt == C_CNT_LAST) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse_out = r_pulse;

endmodule

`default_nettype wire

// File: rtl/ssd_scan_controller.sv
// ============================================================================
// Module : ssd_scan_controller
// Brief  : 4-digit multiplexed hex display of PC/register plus step debouncer.
//          Optional SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int GAP_CYCLES      = 1000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_value,
    input  logic [31:0] reg_value,
    input  logic        sel_pc,
    input  logic        show_upper,
    input  logic        step_btn,
    output logic        step_pulse,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int MAX_CYC = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] C_SHOW_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    scan_state_t      r_state, w_state_nx;
    logic [1:0]       r_d, w_d_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [15:0]      r_frame;
    logic             w_load;
    logic [6:0]       r_seg, w_seg_nx;
    logic [3:0]       r_an, w_an_nx;
    logic [31:0]      w_src;
    logic [15:0]      w_half;
    logic [3:0]       w_nib;
    logic             w_blank;

    assign w_src  = sel_pc ? pc_value : reg_value;
    assign w_half = show_upper ? w_src[31:16] : w_src[15:0];
    assign w_nib  = 4'(r_frame >> {r_d, 2'b00});

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [1:0] w_msn;
    always_comb begin
        w_msn = 2'd0;
        if (r_frame[7:4]   != 4'h0) w_msn = 2'd1;
        if (r_frame[11:8]  != 4'h0) w_msn = 2'd2;
        if (r_frame[15:12] != 4'h0) w_msn = 2'd3;
    end
    assign w_blank = (r_d > w_msn);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_SHOW;
            r_d     <= 2'd0;
            r_cnt   <= '0;
            r_frame <= 16'h0000;
            r_seg   <= C_SEG_BLANK;
            r_an    <= C_AN_OFF;
        end else begin
            r_state <= w_state_nx;
            r_d     <= w_d_nx;
            r_cnt   <= w_cnt_nx;
            r_seg   <= w_seg_nx;
            r_an    <= w_an_nx;
            if (w_load) begin
                r_frame <= w_half;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_d_nx     = r_d;
        w_cnt_nx   = r_cnt + 1'b1;
        w_load     = 1'b0;
        w_seg_nx   = C_SEG_BLANK;
        w_an_nx    = C_AN_OFF;
        case (r_state)
            ST_SHOW: begin
                w_an_nx  = ~(4'b0001 << r_d);
                w_seg_nx = w_blank ? C_SEG_BLANK : C_HEX_SEG[w_nib];
                if (r_cnt == C_SHOW_LAST) begin
                    w_state_nx = ST_GAP;
                    w_cnt_nx   = '0;
                end
            end
            ST_GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_state_nx = ST_SHOW;
                    w_cnt_nx   = '0;
                    w_d_nx     = r_d + 2'd1;
                    // A new frame is latched only at the wrap back to digit 0.
                    w_load     = (r_d == 2'd3);
                end
            end
            default: begin
                w_state_nx = ST_SHOW;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign seg = r_seg;
    assign an  = r_an;

    ssd_step_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (step_btn),
        .pulse_out (step_pulse)
    );

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
// ============================================================================
// Module : tb_ssd_scan_controller
// Brief  : Directed self-checking bench for ssd_scan_controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ssd_scan_controller;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] S0  = 7'b1000000;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ  = BLK;
`else
    localparam logic [6:0] LZ  = S0;
`endif

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      rv;
        logic             sel;
        logic             up;
        logic [3:0][6:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_value = '0;
    logic [31:0] reg_value = '0;
    logic        sel_pc = 1'b0;
    logic        show_upper = 1'b0;
    logic        step_btn = 1'b0;
    logic        step_pulse;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int wide_cnt = 0;
    logic prev_pulse = 1'b0;
    vec_t vecs [7];
    logic [3:0][6:0] zero_exp;

    always #5 clk = ~clk;

    ssd_scan_controller #(
        .SCAN_DIV        (4),
        .GAP_CYCLES      (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_value   (pc_value),
        .reg_value  (reg_value),
        .sel_pc     (sel_pc),
        .show_upper (show_upper),
        .step_btn   (step_btn),
        .step_pulse (step_pulse),
        .seg        (seg),
        .an         (an)
    );

    always @(negedge clk) begin
        if (step_pulse && prev_pulse) wide_cnt <= wide_cnt + 1;
        if (step_pulse && !prev_pulse) pulse_cnt <= pulse_cnt + 1;
        prev_pulse <= step_pulse;
    end

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: an/seg actual %b_%b required %b_%b", nm,
                     act[10:7], act[6:0], req[10:7], req[6:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        pc_value   = v.pc;
        reg_value  = v.rv;
        sel_pc     = v.sel;
        show_upper = v.up;
    endtask

    // Checks one 20-cycle frame; optionally swaps inputs early in the frame.
    task automatic run_frame(input string nm, input logic [3:0][6:0] exp,
                             input bit do_apply, input vec_t nv);
        logic [3:0] ean;
        for (int d = 0; d < 4; d++) begin
            ean = ~(4'b0001 << d);
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                chk($sformatf("%s d%0d k%0d", nm, d, k), {an, seg}, {ean, exp[d]});
                if (do_apply && d == 1 && k == 0) apply(nv);
            end
            @(posedge clk); #1;
            chk($sformatf("%s gap%0d", nm, d), {an, seg}, {4'b1111, BLK});
        end
    endtask

    task automatic step_seq();
        int base;
        base = pulse_cnt;
        @(posedge clk); #2;
        step_btn = 1'b1;
        repeat (3) @(posedge clk);
        #2 step_btn = 1'b0;
        repeat (8) @(posedge clk);
        chk_int("glitch no pulse", pulse_cnt - base, 0);
        for (int i = 0; i < 5; i++) begin
            #2 step_btn = (i % 2 == 0);
            @(posedge clk);
        end
        #2 step_btn = 1'b1;
        repeat (20) @(posedge clk);
        chk_int("press one pulse", pulse_cnt - base, 1);
        chk_int("pulse width", wide_cnt, 0);
        #2 step_btn = 1'b0;
        repeat (20) @(posedge clk);
        chk_int("release no pulse", pulse_cnt - base, 1);
    endtask

    initial begin
        vecs[0] = '{32'h0040_1A3C, 32'h0, 1'b1, 1'b0,
                    {7'b1111001, 7'b0001000, 7'b0110000, 7'b1000110}};
        vecs[1] = '{32'h0040_1A3C, 32'h0000_0007, 1'b0, 1'b0,
                    {LZ, LZ, LZ, 7'b1111000}};
        vecs[2] = '{32'hFFFF_0000, 32'h0000_0007, 1'b1, 1'b1,
                    {7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110}};
        vecs[3] = '{32'hFFFF_0000, 32'h1234_BD59, 1'b0, 1'b1,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[4] = '{32'h0000_0B6D, 32'h1234_BD59, 1'b1, 1'b0,
                    {LZ, 7'b0000011, 7'b0000010, 7'b0100001}};
        vecs[5] = '{32'h0000_0B6D, 32'h0000_E850, 1'b0, 1'b0,
                    {7'b0000110, 7'b0000000, 7'b0010010, S0}};
        vecs[6] = '{32'h0000_0090, 32'h0000_E850, 1'b1, 1'b0,
                    {LZ, LZ, 7'b0010000, S0}};
        zero_exp = {LZ, LZ, LZ, S0};

        apply(vecs[0]);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset outputs", {an, seg}, {4'b1111, BLK});
            chk_int("reset step_pulse", int'(step_pulse), 0);
        end
        reset = 1'b0;

        run_frame("frame0", zero_exp, 1'b0, vecs[0]);
        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].exp, (i < 6), vecs[(i < 6) ? i + 1 : i]);
        end

        fork
            begin
                for (int f = 0; f < 3; f++) run_frame("scan+step", vecs[6].exp, 1'b0, vecs[6]);
            end
            step_seq();
        join

        // Land in the gap after digit 2, then reset.
        repeat (14) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid-gap reset outputs", {an, seg}, {4'b1111, BLK});
        end
        reset = 1'b0;
        run_frame("post-reset frame", zero_exp, 1'b0, vecs[6]);
        run_frame("post-reset reload", vecs[6].exp, 1'b0, vecs[6]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ssd_scan_controller.md
SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles each digit is lit (>=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 1000: clk cycles of all-anodes-off blanking between digits (>=1).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stability window for step button (>=2).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pc_value  in  32  processor PC.
REQ-007 reg_value  in  32  processor register-read value.
REQ-008 sel_pc  in  1  1 = display PC, 0 = display register.
REQ-009 show_upper  in  1  1 = display bits [31:16], 0 = display bits [15:0].
REQ-010 step_btn  in  1  raw asynchronous step button.
REQ-011 step_pulse  out  1  one-cycle processor step strobe.
REQ-012 seg  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-013 an  out  4  active-low anodes, an[0] rightmost, registered.

Function
REQ-014 Scan FSM SHALL have states SHOW and GAP, plus a 2-bit digit index d (0..3).
REQ-015 In SHOW, FSM SHALL stay SCAN_DIV cycles, then enter GAP.
REQ-016 In GAP, FSM SHALL stay GAP_CYCLES cycles, then enter SHOW with d = d+1 mod 4.
REQ-017 On the GAP(d=3) -> SHOW(d=0) transition, block SHALL snapshot sel_pc ? pc_value : reg_value, selected half per show_upper, into a 16-bit frame register; input changes SHALL NOT alter the display mid-frame.
REQ-018 In SHOW, next-cycle outputs SHALL be an = ~(1<<d) and seg = hex encoding of frame nibble d (nibble 0 = bits [3:0]).
REQ-019 In GAP, next-cycle outputs SHALL be an = 4'b1111 and seg = 7'b1111111.
REQ-020 Outputs SHALL lag the FSM state by exactly one cycle.
REQ-021 Hex encoding SHALL light a..f for 0 (7'b1000000), b,c for 1 (7'b1111001), standard upper-/lower-case set for A..F (b, d lowercase).
REQ-022 step_btn SHALL pass through a 2-flop synchronizer; the debounced level SHALL update only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching cycle SHALL clear the counter.
REQ-023 step_pulse SHALL assert for exactly one cycle, in the cycle after the debounced level rises 0->1; never on release; held button SHALL yield one pulse.
REQ-024 Step debouncing and display scanning SHALL be independent; simultaneous events SHALL not delay each other.

Reset
REQ-025 While reset is high: FSM = SHOW, d = 0, all counters = 0, frame = 16'h0000, debounced level = 0, synchronizer = 0, step_pulse = 0, an = 4'b1111, seg = 7'b1111111.
REQ-026 Reset asserted mid-frame or mid-debounce SHALL abandon the operation; first cycle after reset release SHALL show an = 4'b1110, seg = 7'b1000000.

Configuration
REQ-027 Macro SSD_LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero nibble of the frame SHALL output seg = 7'b1111111 (anode still active); digit 0 always displayed.
REQ-028 Macro undefined: all four digits SHALL always display their nibble, including leading zeros.

Structure
REQ-029 Package ssd_pkg SHALL hold the 16-entry hex-to-segment table, blank/all-off constants and the SHOW/GAP state enum.
REQ-030 Debounce and pulse logic SHALL be sub-module ssd_step_debounce (clk, reset, btn_in, pulse_out).

Verification (SCAN_DIV=4, GAP_CYCLES=1, DEBOUNCE_CYCLES=4)
REQ-031 Reset, pc_value=32'h0040_1A3C, sel_pc=1, show_upper=0 -> second frame: an 1110/1101/1011/0111 shows C,3,A,1, each lit 4 cycles, 1 cycle of an=1111 between.
REQ-032 Change sel_pc mid-frame with reg_value=32'h0000_0007 -> current frame unchanged; next frame shows 0007 (macro off) or blank,blank,blank,7 (macro on).
REQ-033 step_btn high for 3 cycles with bounces then steady high 20 cycles -> exactly one step_pulse, 1 cycle wide; release -> no pulse.
REQ-034 Reset asserted during GAP of digit 2 -> outputs all-off while reset high, then an=1110, seg=7'b1000000, frame 0.
REQ-035 show_upper=1, pc_value=32'hFFFF_0000 -> frame shows F,F,F,F on all digits.
